async_pkt_fifo: RTL and testbench
=================================

# async_pkt_fifo

Dual-clock packet FIFO for the switching datapath. It generalises the plain dual-clock FIFO with four additions: parametrised depth and synchroniser length, almost-full/almost-empty thresholds, and packet-mode commit/drop. The read domain sees only complete, committed packets. Beats of a dropped or overflowed packet are never visible to the reader.

## Interface
- DATA_W, 16: data width in bits.
- ADDR_W, 4: address width. DEPTH = 2^ADDR_W entries, each DATA_W+1 bits (data plus last flag).
- SYNC_STAGES, 2: flops per Gray-pointer synchroniser, minimum 2.
- AFULL_TH, 12: afull asserts when write-side occupancy is at least this value (1..DEPTH).
- AEMPTY_TH, 2: aempty asserts when read-side occupancy is at most this value (0..DEPTH-1).

Ports:
- rst_n, in, 1: reset, asynchronous, active-low. Deassertion is synchronised internally per domain with 2 flops.
- wr_clk, in, 1: write clock.
- rd_clk, in, 1: read clock.
- wr_data, in, DATA_W: write beat.
- wr_en, in, 1: write request.
- wr_last, in, 1: marks the final beat of a packet, qualified by wr_en.
- wr_drop, in, 1: abort the open packet.
- full, out, 1: combinational; w_ptr - r_ptr_sync == DEPTH.
- afull, out, 1: combinational; w_ptr - r_ptr_sync >= AFULL_TH.
- wr_cnt, out, ADDR_W+1: registered w_ptr - r_ptr_sync, range 0..DEPTH.
- wr_ovf, out, 1: one-cycle pulse when a beat is rejected.
- rd_data, out, DATA_W: head beat, first-word-fall-through.
- rd_last, out, 1: last flag of the head beat.
- rd_en, in, 1: pop request.
- empty, out, 1: combinational; r_ptr == w_cmt_sync.
- aempty, out, 1: combinational; w_cmt_sync - r_ptr <= AEMPTY_TH.
- rd_cnt, out, ADDR_W+1: registered w_cmt_sync - r_ptr.
- rd_udf, out, 1: one-cycle pulse on rd_en while empty.

## Operation
Pointers are ADDR_W+1 bits wide and wrap modulo 2^(ADDR_W+1). Memory is indexed by the low ADDR_W bits. Three pointers exist:
- w_ptr: speculative write pointer, wr_clk domain.
- w_cmt: commit pointer, wr_clk domain. Only its Gray code crosses to rd_clk.
- r_ptr: read pointer, rd_clk domain. Its Gray code crosses to wr_clk.

Gray conversion is (p>>1)^p. Synchronised Gray values are converted back to binary before subtraction.

Write FSM (wr_clk): IDLE, IN_PKT, DISCARD.
- Accepted beat: wr_en & !full & !wr_drop & state != DISCARD. Writes mem[w_ptr] = {wr_last, wr_data}, then w_ptr += 1.
  - If wr_last is set: w_cmt <= w_ptr+1, next state IDLE.
  - Otherwise: next state IN_PKT.
- Rejected beat: wr_en & full & state != DISCARD.
  - Fires wr_ovf and sets w_ptr <= w_cmt (the open packet is dropped).
  - Next state is IDLE if wr_last is set, otherwise DISCARD.
  - An oversize packet (open length reaches DEPTH) is covered by this rule.
- DISCARD: every wr_en beat is ignored with no wr_ovf. A beat with wr_last returns the FSM to IDLE.
- wr_drop, in any state and with or without wr_en:
  - It has priority over everything else.
  - The current beat is not written, w_ptr <= w_cmt, next state IDLE.
  - w_cmt is unchanged, so earlier committed packets survive.

Read side (rd_clk):
- When empty=0, rd_data and rd_last reflect mem[r_ptr].
- rd_en & !empty: r_ptr += 1.
- rd_en & empty: no pointer change; rd_udf pulses.

Occupancy:
- Write side counts uncommitted beats, because their space is consumed.
- Read side counts committed beats only.

## Timing
Reset values (asynchronous on assertion):
- All pointers, synchronisers, wr_cnt and rd_cnt are 0.
- FSM is IDLE.
- full=0, afull=0, empty=1, aempty=1.
- wr_ovf=0, rd_udf=0, rd_data/rd_last are don't-care while empty.
- Reset mid-packet loses all contents and the open packet.

Latencies:
- Commit at wr_clk edge N: empty deasserts after at most SYNC_STAGES+1 rd_clk edges.
- Pop at rd_clk edge M: full/afull clear after at most SYNC_STAGES+1 wr_clk edges.
- wr_cnt and rd_cnt lag their combinational flags by one cycle of their own clock.
- Pessimism is required: full and empty may assert late-released, never early-released.

Simultaneous events:
- Write of the last free slot with wr_last: accepted, full asserts in the next cycle.
- Read and commit in the same period: both take effect; neither is lost.

## Test plan
- **Single 4-beat packet** (0xA0..0xA3, last on the 4th beat), slow rd_clk. Required: empty=1 through beats 1-3; empty deasserts within SYNC_STAGES+1 rd_clk edges after commit; read returns A0..A3 with rd_last only on A3; rd_cnt goes 4 then 0.
- **Drop mid-packet.** Commit 3-beat packet P1, write 5 beats of P2, assert wr_drop. Required: reader sees only P1; wr_cnt returns to 3; no wr_ovf pulse.
- **Oversize packet**, DEPTH=16, no reads. Write 20 beats with wr_last on beat 20. Required: full at beat 16; one wr_ovf pulse at beat 17; beats 18-20 silent; w_ptr back to 0; empty stays 1; the next 2-beat packet is delivered intact.
- **Thresholds**, AFULL_TH=12, AEMPTY_TH=2. Commit 12 single-beat packets. Required: afull=1 at 12, and 0 after enough reads propagate; aempty=1 for rd_cnt<=2.
- **Error pulses and wrap-around.** rd_en on empty gives one rd_udf pulse. Then stream 100 random packets with wr_clk:rd_clk = 3:7 and 7:3, so pointers wrap many times. Required: scoreboard match, no wr_ovf while full is respected.
- **Reset mid-stream.** Assert rst_n low during an open packet. Required: flags return immediately to their reset values; after release, the first committed packet reads back correctly.

Source files
------------

// File: rtl/async_pkt_fifo.sv
// Dual-clock packet FIFO. Beats are written speculatively and become visible
// to the read domain only when the packet's last beat commits it; dropped or
// overflowed packets are rolled back to the last commit point.
module async_pkt_fifo #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 12,
    parameter int AEMPTY_TH   = 2
) (
    input  logic              rst_n,
    input  logic              wr_clk,
    input  logic              rd_clk,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              wr_last,
    input  logic              wr_drop,
    output logic              full,
    output logic              afull,
    output logic [ADDR_W:0]   wr_cnt,
    output logic              wr_ovf,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_en,
    output logic              empty,
    output logic              aempty,
    output logic [ADDR_W:0]   rd_cnt,
    output logic              rd_udf
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef logic [ADDR_W:0] ptr_t;
    typedef enum logic [1:0] {IDLE, IN_PKT, DISCARD} wr_state_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int unsigned i = 1; i <= ADDR_W; i++) b = b ^ (g >> i);
        return b;
    endfunction

    logic [DATA_W:0] mem [DEPTH];

    logic [1:0] wr_rst_sr, rd_rst_sr;
    logic       wr_rst_n, rd_rst_n;

    wr_state_t state;
    ptr_t      w_ptr, w_cmt, w_cmt_gray, w_ptr_inc;
    ptr_t      r_ptr, r_gray, r_ptr_inc;
    ptr_t      r_ptr_sync, w_cmt_sync, w_used, r_used;
    logic      wr_accept, wr_reject;

    logic [SYNC_STAGES-1:0][ADDR_W:0] r_sync_q;
    logic [SYNC_STAGES-1:0][ADDR_W:0] w_sync_q;

    // Write-domain reset: asserts immediately, releases on wr_clk.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) wr_rst_sr <= '0;
        else        wr_rst_sr <= {wr_rst_sr[0], 1'b1};
    end

    // Read-domain reset: asserts immediately, releases on rd_clk.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) rd_rst_sr <= '0;
        else        rd_rst_sr <= {rd_rst_sr[0], 1'b1};
    end

    assign wr_rst_n = wr_rst_sr[1];
    assign rd_rst_n = rd_rst_sr[1];

    assign w_ptr_inc  = w_ptr + 1'b1;
    assign r_ptr_inc  = r_ptr + 1'b1;
    assign r_ptr_sync = gray2bin(r_sync_q[SYNC_STAGES-1]);
    assign w_cmt_sync = gray2bin(w_sync_q[SYNC_STAGES-1]);

    // Write side counts speculative beats; stale read pointer only overstates use.
    assign w_used = w_ptr - r_ptr_sync;
    assign full   = (w_used == ptr_t'(DEPTH));
    assign afull  = (w_used >= ptr_t'(AFULL_TH));

    // Read side sees committed beats only; stale commit pointer only understates.
    assign r_used = w_cmt_sync - r_ptr;
    assign empty  = (r_ptr == w_cmt_sync);
    assign aempty = (r_used <= ptr_t'(AEMPTY_TH));

    assign wr_accept = wr_en & ~full & ~wr_drop & (state != DISCARD);
    assign wr_reject = wr_en &  full & ~wr_drop & (state != DISCARD);

    // Read-pointer Gray code into the write domain.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) r_sync_q <= '0;
        else           r_sync_q <= {r_sync_q[SYNC_STAGES-2:0], r_gray};
    end

    // Commit-pointer Gray code into the read domain.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) w_sync_q <= '0;
        else           w_sync_q <= {w_sync_q[SYNC_STAGES-2:0], w_cmt_gray};
    end

    // Storage write for accepted beats (data plus last flag).
    always_ff @(posedge wr_clk) begin
        if (wr_accept) mem[w_ptr[ADDR_W-1:0]] <= {wr_last, wr_data};
    end

    // Packet write FSM: speculative pointer, commit, rollback on drop/overflow.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state      <= IDLE;
            w_ptr      <= '0;
            w_cmt      <= '0;
            w_cmt_gray <= '0;
            wr_ovf     <= 1'b0;
            wr_cnt     <= '0;
        end else begin
            wr_ovf <= 1'b0;
            wr_cnt <= w_used;
            if (wr_drop) begin
                w_ptr <= w_cmt;
                state <= IDLE;
            end else if (wr_accept) begin
                w_ptr <= w_ptr_inc;
                if (wr_last) begin
                    w_cmt      <= w_ptr_inc;
                    w_cmt_gray <= bin2gray(w_ptr_inc);
                    state      <= IDLE;
                end else begin
                    state <= IN_PKT;
                end
            end else if (wr_reject) begin
                wr_ovf <= 1'b1;
                w_ptr  <= w_cmt;
                state  <= wr_last ? IDLE : DISCARD;
            end else if (wr_en && (state == DISCARD) && wr_last) begin
                state <= IDLE;
            end
        end
    end

    // Read pointer, registered count and underflow pulse.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_ptr  <= '0;
            r_gray <= '0;
            rd_udf <= 1'b0;
            rd_cnt <= '0;
        end else begin
            rd_udf <= rd_en & empty;
            rd_cnt <= r_used;
            if (rd_en && !empty) begin
                r_ptr  <= r_ptr_inc;
                r_gray <= bin2gray(r_ptr_inc);
            end
        end
    end

    assign {rd_last, rd_data} = mem[r_ptr[ADDR_W-1:0]];

endmodule

// File: tb/tb_async_pkt_fifo.sv
// Bench for async_pkt_fifo: directed packet scenarios plus randomized
// streaming at two clock ratios, checked by a queue-based packet model.
`timescale 1ns/1ps
module tb_async_pkt_fifo;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int AFULL_TH    = 12;
    localparam int AEMPTY_TH   = 2;
    localparam int DEPTH       = 1 << ADDR_W;

    logic              rst_n, wr_clk, rd_clk;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en, wr_last, wr_drop;
    logic              full, afull, wr_ovf;
    logic [ADDR_W:0]   wr_cnt, rd_cnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last, rd_en, empty, aempty, rd_udf;

    int n_tests = 0;
    int n_fail  = 0;

    int wr_half = 5;
    int rd_half = 13;

    // Model: committed-but-unread beats, beats of the open packet, discard mode.
    logic [DATA_W:0] sb[$];
    logic [DATA_W:0] pend[$];
    bit m_disc  = 0;
    bit m_track = 1;

    int unsigned rd_budget = 0;
    int unsigned rd_pct    = 100;
    bit          udf_req   = 0;

    async_pkt_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES),
        .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .rst_n(rst_n), .wr_clk(wr_clk), .rd_clk(rd_clk),
        .wr_data(wr_data), .wr_en(wr_en), .wr_last(wr_last), .wr_drop(wr_drop),
        .full(full), .afull(afull), .wr_cnt(wr_cnt), .wr_ovf(wr_ovf),
        .rd_data(rd_data), .rd_last(rd_last), .rd_en(rd_en),
        .empty(empty), .aempty(aempty), .rd_cnt(rd_cnt), .rd_udf(rd_udf)
    );

    initial begin wr_clk = 0; forever #(wr_half) wr_clk = ~wr_clk; end
    initial begin rd_clk = 0; forever #(rd_half) rd_clk = ~rd_clk; end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Packet-level rules: drop discards the open packet, overflow discards it
    // and skips to its last beat, last beat moves the whole packet to the reader.
    function automatic bit model_write(input logic [DATA_W-1:0] d, input bit last,
                                       input bit drop, input bit en, input bit pfull);
        if (drop) begin pend.delete(); m_disc = 0; return 0; end
        if (!en) return 0;
        if (m_disc) begin if (last) m_disc = 0; return 0; end
        if (pfull) begin pend.delete(); m_disc = !last; return 1; end
        pend.push_back({last, d});
        if (last) while (pend.size() > 0) sb.push_back(pend.pop_front());
        return 0;
    endfunction

    task automatic wr_beat(input logic [DATA_W-1:0] d, input bit last, input bit drop,
                           input bit en, input bit fc);
        int occ;
        int guard;
        bit eovf;
        @(negedge wr_clk);
        guard = 0;
        while (fc && full && en && !drop) begin
            @(negedge wr_clk);
            guard++;
            if (guard > 5000) timeout_fail("wr_flow_control");
        end
        occ = sb.size() + pend.size();
        wr_data = d; wr_last = last; wr_drop = drop; wr_en = en;
        eovf = model_write(d, last, drop, en, m_track && (occ == DEPTH));
        @(posedge wr_clk); #1;
        check("wr_ovf", 32'(wr_ovf), 32'(eovf));
        if (m_track) begin
            check("wr_cnt", 32'(wr_cnt), 32'(occ));
            check("full",  32'(full),  32'((sb.size() + pend.size()) == DEPTH));
            check("afull", 32'(afull), 32'((sb.size() + pend.size()) >= AFULL_TH));
        end
        wr_en = 0; wr_last = 0; wr_drop = 0;
    endtask

    task automatic drain(input int unsigned pct);
        int guard;
        guard = 0;
        rd_pct = pct;
        rd_budget = 1000000;
        while (sb.size() != 0) begin
            @(posedge rd_clk);
            guard++;
            if (guard > 20000) timeout_fail("drain");
        end
        rd_budget = 0;
        repeat (8) @(posedge rd_clk);
        repeat (8) @(posedge wr_clk);
        #1;
        check("empty_after_drain",  32'(empty),  32'd1);
        check("rd_cnt_after_drain", 32'(rd_cnt), 32'd0);
        check("wr_cnt_after_drain", 32'(wr_cnt), 32'(pend.size()));
    endtask

    task automatic stream(input int npkt);
        int len;
        int drop_at;
        rd_pct = 50;
        rd_budget = 1000000;
        for (int p = 0; p < npkt; p++) begin
            len = int'($urandom_range(1, 8));
            drop_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            for (int b = 0; b < len; b++) begin
                if (b == drop_at) begin
                    wr_beat(16'($urandom), 0, 1, 1'($urandom_range(0, 1)), 1);
                    break;
                end
                wr_beat(16'($urandom), b == len - 1, 0, 1, 1);
                if ($urandom_range(0, 3) == 0) @(negedge wr_clk);
            end
        end
    endtask

    // Reader stimulus: pops only when permitted; can force one pop on empty.
    initial begin
        rd_en = 0;
        forever begin
            @(negedge rd_clk);
            if (udf_req) begin
                rd_en = 1;
                udf_req = 0;
            end else if (!empty && rd_budget > 0 && $urandom_range(0, 99) < rd_pct) begin
                rd_en = 1;
                rd_budget--;
            end else begin
                rd_en = 0;
            end
        end
    end

    // Monitor: every popped head beat must be the oldest committed model beat.
    initial begin
        logic [DATA_W:0] exp;
        forever begin
            @(negedge rd_clk); #1;
            if (rd_en && !empty) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got %0h expected no beat", {rd_last, rd_data});
                end else begin
                    exp = sb.pop_front();
                    check("rd_beat", 32'({rd_last, rd_data}), 32'(exp));
                end
            end
        end
    end

    initial begin
        #2000000;
        timeout_fail("watchdog");
    end

    initial begin
        bit found;
        rst_n = 0; wr_data = '0; wr_en = 0; wr_last = 0; wr_drop = 0;
        #37;
        check("rst_full",   32'(full),   32'd0);
        check("rst_afull",  32'(afull),  32'd0);
        check("rst_empty",  32'(empty),  32'd1);
        check("rst_aempty", 32'(aempty), 32'd1);
        check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        check("rst_wr_ovf", 32'(wr_ovf), 32'd0);
        check("rst_rd_udf", 32'(rd_udf), 32'd0);
        rst_n = 1;
        repeat (5) @(posedge wr_clk);
        repeat (5) @(posedge rd_clk);

        // Underflow pulse
        udf_req = 1;
        for (int k = 0; k < 6 && udf_req; k++) begin @(negedge rd_clk); #1; end
        @(posedge rd_clk); #1;
        check("rd_udf_pulse", 32'(rd_udf), 32'd1);
        @(posedge rd_clk); #1;
        check("rd_udf_clear", 32'(rd_udf), 32'd0);
        check("empty_after_udf", 32'(empty), 32'd1);

        // Single 4-beat packet, slow read clock
        for (int i = 0; i < 3; i++) wr_beat(16'(16'hA0 + i), 0, 0, 1, 0);
        repeat (5) begin @(posedge rd_clk); #1; check("empty_open_pkt", 32'(empty), 32'd1); end
        wr_beat(16'hA3, 1, 0, 1, 0);
        found = 0;
        for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
            @(posedge rd_clk); #1;
            if (!empty) begin found = 1; break; end
        end
        check("commit_latency", 32'(found), 32'd1);
        @(posedge rd_clk); #1;
        check("rd_cnt_pkt", 32'(rd_cnt), 32'd4);
        check("aempty_pkt", 32'(aempty), 32'd0);
        drain(100);

        // Drop mid-packet
        for (int i = 0; i < 3; i++) wr_beat(16'(16'hB0 + i), i == 2, 0, 1, 0);
        for (int i = 0; i < 5; i++) wr_beat(16'(16'hC0 + i), 0, 0, 1, 0);
        wr_beat(16'h0, 0, 1, 0, 0);
        @(posedge wr_clk); #1;
        check("wr_cnt_after_drop", 32'(wr_cnt), 32'd3);
        drain(60);

        // Oversize packet with no reads
        for (int i = 1; i <= 20; i++) wr_beat(16'(16'hD0 + i), i == 20, 0, 1, 0);
        repeat (6) @(posedge rd_clk); #1;
        check("empty_after_oversize", 32'(empty), 32'd1);
        wr_beat(16'hE0, 0, 0, 1, 0);
        wr_beat(16'hE1, 1, 0, 1, 0);
        drain(100);

        // Thresholds
        for (int i = 0; i < 12; i++) wr_beat(16'(16'h100 + i), 1, 0, 1, 0);
        repeat (SYNC_STAGES + 3) @(posedge rd_clk); #1;
        check("rd_cnt_thr_full", 32'(rd_cnt), 32'd12);
        check("aempty_thr_full", 32'(aempty), 32'd0);
        for (int k = 11; k >= 0; k--) begin
            rd_pct = 100;
            rd_budget = 1;
            repeat (4) @(posedge rd_clk); #1;
            check("rd_cnt_thr", 32'(rd_cnt), 32'(k));
            check("aempty_thr", 32'(aempty), 32'(k <= AEMPTY_TH));
            check("afull_thr", 32'(afull), 32'(k >= AFULL_TH));
        end
        drain(100);

        // Random streaming at 3:7 and 7:3, pointers wrap many times
        m_track = 0;
        wr_half = 3; rd_half = 7;
        stream(50);
        drain(100);
        wr_half = 7; rd_half = 3;
        stream(50);
        drain(100);

        // Reset during an open packet
        m_track = 1;
        wr_half = 5; rd_half = 13;
        repeat (4) @(posedge wr_clk);
        wr_beat(16'hF0, 0, 0, 1, 0);
        wr_beat(16'hF1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) wr_beat(16'(16'hF2 + i), 0, 0, 1, 0);
        repeat (6) @(posedge rd_clk); #1;
        check("empty_before_reset", 32'(empty), 32'd0);
        @(negedge wr_clk); #2;
        rst_n = 0;
        #1;
        check("mid_rst_full",   32'(full),   32'd0);
        check("mid_rst_afull",  32'(afull),  32'd0);
        check("mid_rst_empty",  32'(empty),  32'd1);
        check("mid_rst_aempty", 32'(aempty), 32'd1);
        check("mid_rst_wr_cnt", 32'(wr_cnt), 32'd0);
        check("mid_rst_rd_cnt", 32'(rd_cnt), 32'd0);
        sb.delete(); pend.delete(); m_disc = 0;
        #40;
        rst_n = 1;
        repeat (5) @(posedge wr_clk);
        repeat (5) @(posedge rd_clk);
        for (int i = 0; i < 3; i++) wr_beat(16'(16'h5A0 + i), i == 2, 0, 1, 0);
        drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
